// File: rtl/bram_stream_reader.sv
// Burst reader for one port of a dual-port block RAM: issues credit-limited reads and
// returns the words in address order as a valid/ready stream tagged with a last flag.
module bram_stream_reader #(
   parameter int DATA_W     = 128,
   parameter int ADDR_W     = 14,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [ADDR_W-1:0] cmd_len,
   output logic              bram_en,
   output logic              bram_we,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [DATA_W-1:0] bram_din,
   input  logic [DATA_W-1:0] bram_dout,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   output logic              busy
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

   state_t             state_q;
   logic               cmd_ready_q, busy_q;
   logic               en_q, en_last_q;
   logic               cap_q, cap_last_q;
   logic [ADDR_W-1:0]  bram_addr_q, addr_q, rem_q;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [CNT_W:0]     occ_d;
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [DATA_W-1:0]  mem_q      [FIFO_DEPTH];
   logic               mem_last_q [FIFO_DEPTH];
   logic               valid_w, push, pop, credit_ok, head_last;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   assign valid_w   = (count_q != '0);
   assign head_last = mem_last_q[rd_ptr_q];

   // Credit counts buffered words plus both reads still in the RAM pipeline.
   always_comb begin
      push      = cap_q;
      pop       = valid_w & m_ready;
      count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
      occ_d     = {1'b0, count_d} + (CNT_W + 1)'(en_q);
      credit_ok = (occ_d < DEPTH_C);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         en_q        <= 1'b0;
         en_last_q   <= 1'b0;
         cap_q       <= 1'b0;
         cap_last_q  <= 1'b0;
         bram_addr_q <= '0;
         addr_q      <= '0;
         rem_q       <= '0;
         count_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
      end else begin
         en_q       <= 1'b0;
         en_last_q  <= 1'b0;
         cap_q      <= en_q;
         cap_last_q <= en_last_q;
         count_q    <= count_d;
         if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);

         case (state_q)
            S_IDLE: begin
               if (cmd_valid && cmd_ready_q) begin
                  en_q        <= 1'b1;
                  bram_addr_q <= cmd_addr;
                  addr_q      <= cmd_addr + ADDR_W'(1);
                  rem_q       <= cmd_len - ADDR_W'(1);
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  if (cmd_len == '0) begin
                     en_last_q <= 1'b1;
                     state_q   <= S_DRAIN;
                  end else begin
                     state_q   <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               if (credit_ok) begin
                  en_q        <= 1'b1;
                  bram_addr_q <= addr_q;
                  addr_q      <= addr_q + ADDR_W'(1);
                  rem_q       <= rem_q - ADDR_W'(1);
                  if (rem_q == '0) begin
                     en_last_q <= 1'b1;
                     state_q   <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (pop && head_last) begin
                  cmd_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // RAM read data is valid only in the cycle after an enabled read.
   always_ff @(posedge clk) begin
      if (cap_q) begin
         mem_q[wr_ptr_q]      <= bram_dout;
         mem_last_q[wr_ptr_q] <= cap_last_q;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign busy      = busy_q;
   assign bram_en   = en_q;
   assign bram_we   = 1'b0;
   assign bram_addr = bram_addr_q;
   assign bram_din  = '0;
   assign m_valid   = valid_w;
   assign m_data    = valid_w ? mem_q[rd_ptr_q] : '0;
   assign m_last    = valid_w & head_last;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Randomized bench for bram_stream_reader: RAM model plus a queue-based reference of
// expected read addresses and output beats derived from each accepted command.
module tb_bram_stream_reader;
   localparam int DW = 128;
   localparam int AW = 14;
   localparam int FD = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid, cmd_ready;
   logic [AW-1:0] cmd_addr, cmd_len;
   logic          bram_en, bram_we;
   logic [AW-1:0] bram_addr;
   logic [DW-1:0] bram_din, bram_dout;
   logic          m_valid, m_ready, m_last, busy;
   logic [DW-1:0] m_data;

   always #5 clk = ~clk;

   bram_stream_reader #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
      .bram_dout(bram_dout),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .busy(busy)
   );

   function automatic logic [DW-1:0] word_of(input int i);
      return {32'hC0DE_0000 | 32'(i), 32'(i), ~32'(i), 32'(i * i + 7)};
   endfunction

   // RAM model; non-read cycles present garbage so mistimed sampling is visible.
   logic [DW-1:0] ram [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (bram_en) bram_dout <= ram[bram_addr];
      else         bram_dout <= {$urandom, $urandom, $urandom, $urandom};
   end

   int            total = 0, bad = 0;
   int            cyc = 0, acc_cyc = 0, issued = 0, popped = 0;
   int            burst_beats = 0, burst_issued = 0, first_pop_cyc = 0, last_pop_cyc = 0;
   bit            active = 0, wait_first = 0, stall_prev = 0;
   logic [DW-1:0] prev_data;
   logic          prev_last;
   logic [AW-1:0] aq [$];
   logic [DW:0]   dq [$];

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic monitor();
      logic [DW:0]   e;
      logic [AW-1:0] a;
      check("bram_we", DW'(bram_we), '0);
      check("bram_din", bram_din, '0);
      if (!rst_n) begin
         check("rst_m_valid", DW'(m_valid), '0);
         check("rst_bram_en", DW'(bram_en), '0);
         check("rst_busy", DW'(busy), '0);
         check("rst_m_last", DW'(m_last), '0);
         check("rst_m_data", m_data, '0);
         check("rst_bram_addr", DW'(bram_addr), '0);
         aq.delete(); dq.delete();
         active = 0; wait_first = 0; stall_prev = 0; issued = 0; popped = 0;
         return;
      end
      check("busy", DW'(busy), DW'(active));
      check("cmd_ready", DW'(cmd_ready), DW'(!active));
      if (bram_en) begin
         issued++; burst_issued++;
         if (aq.size() == 0) check("extra_en", DW'(1), '0);
         else check("bram_addr", DW'(bram_addr), DW'(aq.pop_front()));
         check("credit", DW'((issued - popped) <= FD), DW'(1));
      end
      if (wait_first && m_valid) begin
         check("first_latency", DW'(cyc - acc_cyc), DW'(2));
         wait_first = 0;
      end
      if (stall_prev) begin
         check("stall_valid", DW'(m_valid), DW'(1));
         check("stall_data", m_data, prev_data);
         check("stall_last", DW'(m_last), DW'(prev_last));
      end
      if (m_valid) begin
         if (dq.size() == 0) check("spurious_valid", DW'(1), '0);
         else if (m_ready) begin
            e = dq.pop_front();
            check("m_data", m_data, e[DW-1:0]);
            check("m_last", DW'(m_last), DW'(e[DW]));
            popped++;
            if (burst_beats == 0) first_pop_cyc = cyc;
            burst_beats++;
            if (e[DW]) begin active = 0; last_pop_cyc = cyc; end
         end
      end
      stall_prev = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (cmd_valid && cmd_ready) begin
         check("no_overlap", DW'(dq.size() + aq.size()), '0);
         for (int k = 0; k <= int'(cmd_len); k++) begin
            a = cmd_addr + AW'(k);
            aq.push_back(a);
            dq.push_back({k == int'(cmd_len), word_of(int'(a))});
         end
         active = 1; wait_first = 1; acc_cyc = cyc + 1; burst_beats = 0; burst_issued = 0;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic send_cmd(input logic [AW-1:0] addr, input logic [AW-1:0] len);
      int b = 0;
      cmd_addr  = addr;
      cmd_len   = len;
      cmd_valid = 1'b1;
      while (!cmd_ready && b < 3000) begin tick(); b++; end
      if (b >= 3000) check("cmd_timeout", DW'(0), DW'(1));
      tick();
      cmd_valid = 1'b0;
   endtask

   // mode 0: ready held high; 1: random; 2: low 20 cycles then random
   task automatic wait_done(input int mode);
      int b = 0;
      while (active && b < 5000) begin
         case (mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'($urandom % 2);
            default: m_ready = (b < 20) ? 1'b0 : 1'($urandom % 2);
         endcase
         tick();
         b++;
      end
      if (b >= 5000) check("done_timeout", DW'(0), DW'(1));
      m_ready = 1'b1;
   endtask

   initial begin
      int b;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; m_ready = 1'b0;
      for (int i = 0; i < (1 << AW); i++) ram[i] = word_of(i);
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      m_ready = 1'b1;
      send_cmd(14'h0010, 14'd0);
      wait_done(0);
      check("t1_en_pulses", DW'(burst_issued), DW'(1));
      check("t1_beats", DW'(burst_beats), DW'(1));

      send_cmd(14'h0100, 14'd7);
      wait_done(0);
      check("t2_beats", DW'(burst_beats), DW'(8));
      check("t2_span", DW'(last_pop_cyc - first_pop_cyc), DW'(7));

      send_cmd(14'h3FFE, 14'd3);
      wait_done(0);
      check("t3_beats", DW'(burst_beats), DW'(4));

      m_ready = 1'b0;
      send_cmd(AW'($urandom), 14'd15);
      wait_done(2);
      check("t4_beats", DW'(burst_beats), DW'(16));

      for (int r = 0; r < 6; r++) begin
         m_ready = 1'($urandom % 2);
         send_cmd(AW'($urandom), AW'($urandom_range(0, 40)));
         wait_done(1);
      end

      m_ready = 1'b1;
      send_cmd(14'h0200, 14'd31);
      b = 0;
      while (burst_beats < 5 && b < 500) begin tick(); b++; end
      if (b >= 500) check("t5_timeout", DW'(0), DW'(1));
      rst_n = 1'b0;
      #1;
      check("t5_async_m_valid", DW'(m_valid), '0);
      check("t5_async_bram_en", DW'(bram_en), '0);
      check("t5_async_busy", DW'(busy), '0);
      check("t5_async_m_data", m_data, '0);
      repeat (3) tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("t5_idle_valid", DW'(m_valid), '0);
      end
      send_cmd(14'h0050, 14'd1);
      wait_done(0);
      check("t5_beats", DW'(burst_beats), DW'(2));

      send_cmd(14'h0400, 14'd5);
      send_cmd(14'h0410, 14'd2);
      wait_done(0);
      check("t6_beats", DW'(burst_beats), DW'(3));

      repeat (3) tick();
      check("leftover", DW'(dq.size() + aq.size()), '0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
